ram_arbiter: RTL

- Shares one single-port 256x8 synchronous RAM between two requesters:
  - port A: the SPI command engine.
  - port B: local fabric logic.
- Each access is a single read or write under a req/ack handshake. Grants are round-robin.
- A lock input lets the current owner hold the RAM for a bounded burst, so SPI streaming reads and writes are not interleaved.
- Sits between the SPI command state machine and the RAM instance; owns every RAM control signal.

---
 rtl/ram_arbiter.sv | 131 +++++++++++++
 1 files changed

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous RAM between the SPI
// command engine (port A) and local fabric logic (port B), with bounded locked bursts.
module ram_arbiter #(
  parameter int AW        = 8,
  parameter int DW        = 8,
  parameter int MAX_BURST = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          a_req,
  input  logic          a_we,
  input  logic          a_lock,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_ack,
  output logic [DW-1:0] a_rdata,
  input  logic          b_req,
  input  logic          b_we,
  input  logic          b_lock,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_ack,
  output logic [DW-1:0] b_rdata,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  typedef enum logic {GNT_A, GNT_B} port_t;

  localparam logic [7:0] BURST_MAX = 8'(MAX_BURST);

  state_t        state, state_nx;
  port_t         owner, owner_nx;
  port_t         last_grant, last_grant_nx;
  logic [7:0]    burst_cnt, burst_cnt_nx;
  logic          load_mem;
  logic          own_req, own_lock, other_req;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic [DW-1:0] a_rdata_q, b_rdata_q;

  always_comb begin
    own_req   = (owner == GNT_A) ? a_req  : b_req;
    own_lock  = (owner == GNT_A) ? a_lock : b_lock;
    other_req = (owner == GNT_A) ? b_req  : a_req;
  end

  always_comb begin
    state_nx      = state;
    owner_nx      = owner;
    last_grant_nx = last_grant;
    burst_cnt_nx  = burst_cnt;
    load_mem      = 1'b0;
    case (state)
      IDLE: begin
        if (a_req && (!b_req || last_grant == GNT_B)) begin
          state_nx      = ACCESS;
          owner_nx      = GNT_A;
          last_grant_nx = GNT_A;
          burst_cnt_nx  = 8'd1;
          load_mem      = 1'b1;
        end else if (b_req) begin
          state_nx      = ACCESS;
          owner_nx      = GNT_B;
          last_grant_nx = GNT_B;
          burst_cnt_nx  = 8'd1;
          load_mem      = 1'b1;
        end
      end
      ACCESS: state_nx = RESP;
      RESP: begin
        // An expired lock keeps the grant only while the peer is idle; count saturates.
        if (own_lock && own_req && (burst_cnt < BURST_MAX || !other_req)) begin
          state_nx = ACCESS;
          load_mem = 1'b1;
          if (burst_cnt < BURST_MAX) burst_cnt_nx = burst_cnt + 8'd1;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    sel_we    = (owner_nx == GNT_A) ? a_we    : b_we;
    sel_addr  = (owner_nx == GNT_A) ? a_addr  : b_addr;
    sel_wdata = (owner_nx == GNT_A) ? a_wdata : b_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      owner      <= GNT_A;
      last_grant <= GNT_B;
      burst_cnt  <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_we     <= 1'b0;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
    end else begin
      state      <= state_nx;
      owner      <= owner_nx;
      last_grant <= last_grant_nx;
      burst_cnt  <= burst_cnt_nx;
      mem_we     <= load_mem && sel_we;
      if (load_mem) begin
        mem_addr  <= sel_addr;
        mem_wdata <= sel_wdata;
      end
      if (state == RESP && owner == GNT_A) a_rdata_q <= mem_rdata;
      if (state == RESP && owner == GNT_B) b_rdata_q <= mem_rdata;
    end
  end

  // RAM data arrives in RESP, so rdata passes through there and is held afterwards.
  always_comb begin
    a_ack   = (state == RESP) && (owner == GNT_A);
    b_ack   = (state == RESP) && (owner == GNT_B);
    a_rdata = a_ack ? mem_rdata : a_rdata_q;
    b_rdata = b_ack ? mem_rdata : b_rdata_q;
    busy    = (state != IDLE);
  end

endmodule
